// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FIFO sequencing states and default FIFO depth.
package uart_pkg;

  typedef enum logic [1:0] {TX_IDLE, TX_BUSY, TX_GAP} tx_state_t;

  localparam int unsigned UART_TX_FIFO_DEPTH = 16;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// CSR-side push channel into the transmit FIFO.
interface uart_tx_fifo_if;

  logic       push_valid;
  logic [7:0] push_data;
  logic       push_ready;
  logic       flush;

  modport master (
    output push_valid,
    output push_data,
    output flush,
    input  push_ready
  );

  modport slave (
    input  push_valid,
    input  push_data,
    input  flush,
    output push_ready
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// DEPTH x 8 register array: one synchronous write port, asynchronous read port.
module uart_fifo_mem #(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_transmission one frame at a time; owns tx_data/tx_start.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = UART_TX_FIFO_DEPTH,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  uart_tx_fifo_if.slave        push_if,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 clear_req,
  output logic [AW:0]          level,
  output logic                 empty,
  output logic                 full,
  output logic                 overflow,
  input  logic                 irq_en,
  output logic                 irq
);

  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  tx_state_t     state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_start_q, tx_start_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    rd_byte;
  logic          push_acc, pop;

  assign full     = (count_q == FullCount);
  assign empty    = (count_q == '0);
  assign level    = count_q;
  assign irq      = irq_en & empty & (state_q == TX_IDLE);
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign overflow = overflow_q;

  assign push_if.push_ready = ~full;
  // Flush beats a concurrent push; full is judged on the registered count only.
  assign push_acc = push_if.push_valid & ~full & ~push_if.flush;

  uart_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (wb_clk_i),
    .we_i    (push_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (push_if.push_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_byte)
  );

  always_comb begin
    state_d    = state_q;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;
    pop        = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        if (!empty && !push_if.flush) begin
          pop        = 1'b1;
          tx_data_d  = rd_byte;
          tx_start_d = 1'b1;
          state_d    = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (clear_req) begin
          tx_start_d = 1'b0;
          state_d    = TX_GAP;
        end
      end
      TX_GAP: begin
        state_d = TX_IDLE;
      end
      default: begin
        tx_start_d = 1'b0;
        state_d    = TX_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + AW'(push_acc);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + (AW+1)'(push_acc) - (AW+1)'(pop);
    overflow_d = overflow_q | (push_if.push_valid & full);
    if (push_if.flush) begin
      rd_ptr_d   = wr_ptr_q;
      count_d    = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= TX_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      overflow_q <= overflow_d;
    end
  end

endmodule
